// File: rtl/r_shift_sfr_if.sv
// rtl/r_shift_sfr_if.sv - control, data and status bundle for the right-shift SFR
interface r_shift_sfr_if #(
    parameter int SIZE  = 32,
    parameter int CNT_W = $clog2(SIZE + 1)
);
    logic             clr;
    logic             load;
    logic [SIZE-1:0]  din;
    logic             right;
    logic             decr;
    logic             arith;
    logic             sin;
    logic             start;
    logic [SIZE-1:0]  Q;
    logic             sout;
    logic             sout_valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             empty;
    logic             ovr;
    logic             busy;
    logic             done;

    modport master (
        output clr, load, din, right, decr, arith, sin, start,
        input  Q, sout, sout_valid, bit_cnt, empty, ovr, busy, done
    );

    modport slave (
        input  clr, load, din, right, decr, arith, sin, start,
        output Q, sout, sout_valid, bit_cnt, empty, ovr, busy, done
    );
endinterface

// File: rtl/r_shift_sfr.sv
// rtl/r_shift_sfr.sv - right-shift SFR: parallel load, LSB-first serial unload, decrement
module r_shift_sfr #(
    parameter int SIZE  = 32,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    r_shift_sfr_if.slave  sfr
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, next_state;
    logic [SIZE-1:0]  q;
    logic             sout_r;
    logic             sout_valid_r;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovr;
    logic             done_r;

    logic             do_load;
    logic             do_shift;
    logic             do_decr;
    logic             set_done;
    logic [SIZE-1:0]  q_dec;
    logic [SIZE-1:0]  src;
    logic             fill;

    // Decrement feeds the shifter so decr+shift in one cycle shifts the decremented value.
    assign q_dec = q - 1'b1;
    assign src   = do_decr ? q_dec : q;
    assign fill  = sfr.arith ? src[SIZE-1] : sfr.sin;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_decr    = 1'b0;
        set_done   = 1'b0;
        if (sfr.clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    do_load = sfr.load;
                    if (sfr.start) begin
                        if (sfr.load || bit_cnt != '0) begin
                            next_state = BUSY;
                        end else begin
                            set_done = 1'b1;
                        end
                    end
                    if (!sfr.load) begin
                        do_decr  = sfr.decr;
                        do_shift = sfr.right && !(sfr.start && bit_cnt != '0);
                    end
                end
                BUSY: begin
                    do_shift = 1'b1;
                    if (bit_cnt <= CNT_W'(1)) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                    set_done   = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q            <= '0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            bit_cnt      <= '0;
            ovr          <= 1'b0;
            done_r       <= 1'b0;
        end else if (sfr.clr) begin
            q            <= '0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            bit_cnt      <= '0;
            ovr          <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            sout_valid_r <= do_shift;
            done_r       <= set_done;
            if (do_load) begin
                q       <= sfr.din;
                bit_cnt <= CNT_W'(SIZE);
                ovr     <= 1'b0;
            end else if (do_shift) begin
                q      <= {fill, src[SIZE-1:1]};
                sout_r <= src[0];
                // Shifting an empty register still moves Q but flags the underrun.
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (do_decr) begin
                q <= q_dec;
            end
        end
    end

    assign sfr.Q          = q;
    assign sfr.sout       = sout_r;
    assign sfr.sout_valid = sout_valid_r;
    assign sfr.bit_cnt    = bit_cnt;
    assign sfr.empty      = (bit_cnt == '0);
    assign sfr.ovr        = ovr;
    assign sfr.busy       = (state == BUSY);
    assign sfr.done       = done_r;
endmodule
